// File: rtl/fire_controller.sv
// fire_controller: turns the player's fire key into a one-cycle shooting pulse
// for the missile pool. It enforces a frame-based cooldown between shots,
// tracks the rounds left in the magazine and runs a timed reload, either when
// the magazine empties or on a manual reload request.
module fire_controller #(
    parameter int MAG_SIZE        = 5,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int RELOAD_FRAMES   = 60,
    parameter bit AUTO_FIRE       = 1'b0
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       fire_key,
    input  logic       reload_key,
    output logic       shooting_pulse,
    output logic [3:0] ammo_count,
    output logic       reloading,
    output logic       cooldown_active
);

    localparam logic [3:0] MAG_VAL = 4'(MAG_SIZE);
    localparam logic [7:0] CD_VAL  = 8'(COOLDOWN_FRAMES);
    localparam logic [7:0] RLD_VAL = 8'(RELOAD_FRAMES);

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_RELOAD   = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] cd_cnt_r;
    logic [7:0] cd_cnt_s;
    logic [7:0] rld_cnt_r;
    logic [7:0] rld_cnt_s;
    logic [3:0] ammo_r;
    logic [3:0] ammo_s;
    logic       fire_key_d_r;
    logic       reload_key_d_r;
    logic       pulse_r;
    logic       pulse_s;
    logic       reloading_r;
    logic       cooldown_active_r;
    logic       fire_edge_s;
    logic       rld_edge_s;
    logic       fire_req_s;

    assign shooting_pulse  = pulse_r;
    assign ammo_count      = ammo_r;
    assign reloading       = reloading_r;
    assign cooldown_active = cooldown_active_r;

    // Key edge detection, fire request selection, and next-state/next-output decode.
    always_comb begin
        fire_edge_s = fire_key & ~fire_key_d_r;
        rld_edge_s  = reload_key & ~reload_key_d_r;
        fire_req_s  = AUTO_FIRE ? fire_key : fire_edge_s;

        state_s   = state_r;
        cd_cnt_s  = cd_cnt_r;
        rld_cnt_s = rld_cnt_r;
        ammo_s    = ammo_r;
        pulse_s   = 1'b0;

        case (state_r)
            ST_READY: begin
                // A fire request outranks a reload request in the same cycle.
                if (fire_req_s && (ammo_r != 4'd0)) begin
                    pulse_s = 1'b1;
                    ammo_s  = ammo_r - 4'd1;
                    if (ammo_r == 4'd1) begin
                        state_s   = ST_RELOAD;
                        rld_cnt_s = RLD_VAL;
                    end else begin
                        state_s  = ST_COOLDOWN;
                        cd_cnt_s = CD_VAL;
                    end
                end else if (rld_edge_s && (ammo_r < MAG_VAL)) begin
                    state_s   = ST_RELOAD;
                    rld_cnt_s = RLD_VAL;
                end else begin
                    state_s = ST_READY;
                end
            end
            ST_COOLDOWN: begin
                // Requests arriving here are dropped; only frames are counted.
                if (startOfFrame) begin
                    cd_cnt_s = cd_cnt_r - 8'd1;
                    if (cd_cnt_r == 8'd1) begin
                        state_s = ST_READY;
                    end else begin
                        state_s = ST_COOLDOWN;
                    end
                end else begin
                    cd_cnt_s = cd_cnt_r;
                end
            end
            ST_RELOAD: begin
                if (startOfFrame) begin
                    rld_cnt_s = rld_cnt_r - 8'd1;
                    if (rld_cnt_r == 8'd1) begin
                        ammo_s  = MAG_VAL;
                        state_s = ST_READY;
                    end else begin
                        state_s = ST_RELOAD;
                    end
                end else begin
                    rld_cnt_s = rld_cnt_r;
                end
            end
            default: begin
                // Unreachable encoding: recover to a safe, idle state.
                state_s   = ST_READY;
                cd_cnt_s  = 8'd0;
                rld_cnt_s = 8'd0;
            end
        endcase
    end

    // State, counters, key history and registered outputs; reset forces keys as held.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_r           <= ST_READY;
            cd_cnt_r          <= 8'd0;
            rld_cnt_r         <= 8'd0;
            ammo_r            <= MAG_VAL;
            fire_key_d_r      <= 1'b1;
            reload_key_d_r    <= 1'b1;
            pulse_r           <= 1'b0;
            reloading_r       <= 1'b0;
            cooldown_active_r <= 1'b0;
        end else begin
            state_r           <= state_s;
            cd_cnt_r          <= cd_cnt_s;
            rld_cnt_r         <= rld_cnt_s;
            ammo_r            <= ammo_s;
            fire_key_d_r      <= fire_key;
            reload_key_d_r    <= reload_key;
            pulse_r           <= pulse_s;
            reloading_r       <= (state_s == ST_RELOAD);
            cooldown_active_r <= (state_s == ST_COOLDOWN);
        end
    end

endmodule
